// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC steering, imem req/ack, decode hand-off
//
// Purpose
//   Fetches the instruction at pc from instruction memory and holds it for decode.
//   Drives pcNext back into the external PC register: hold, step, or redirect on branch.
//   A branch that arrives while a request is outstanding marks the in-flight data as
//   stale (r_flush) so it is dropped when the memory finally answers.
//
// Ports
//   clk, reset                 clock / asynchronous active-low reset
//   pc, pcNext                 current PC in, next PC out (combinational)
//   imem_req, imem_addr        memory request and address (address stable while waiting)
//   imem_ack, imem_rdata       memory response strobe and instruction word
//   branch_taken/target        redirect pulse and destination from execute
//   inst_valid/inst/inst_pc    held instruction towards decode
//   inst_ready                 decode accepts the held instruction

module instr_fetch #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               STEP     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pcNext,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [WIDTH-1:0] inst_pc,
    input  logic             inst_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_flush;
    logic [WIDTH-1:0] r_req_addr;
    logic             r_inst_valid;
    logic [31:0]      r_inst;
    logic [WIDTH-1:0] r_inst_pc;

    logic             w_req;
    logic [WIDTH-1:0] w_addr;
    logic             w_ack;

    // Request is a pure decode of the state register, so it is glitch free.
    // In FETCH the address comes straight from pc (loaded on the same edge that
    // entered FETCH); afterwards the latched copy keeps it stable until ack.
    always_comb begin
        w_req  = (r_state == S_FETCH) || (r_state == S_WAIT);
        w_addr = '0;
        if (r_state == S_FETCH) begin
            w_addr = pc;
        end else if (r_state == S_WAIT) begin
            w_addr = r_req_addr;
        end
        w_ack  = w_req && imem_ack;
    end

    always_comb begin
        pcNext = pc;
        if (!reset) begin
            pcNext = RESET_PC;
        end else if (branch_taken) begin
            pcNext = branch_target;
        end else if (w_ack && !r_flush) begin
            pcNext = pc + WIDTH'(STEP);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_flush      <= 1'b0;
            r_req_addr   <= '0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH, S_WAIT: begin
                    if (r_state == S_FETCH) begin
                        r_req_addr <= pc;
                    end
                    if (imem_ack) begin
                        if (!r_flush && !branch_taken) begin
                            r_inst       <= imem_rdata;
                            r_inst_pc    <= w_addr;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end else begin
                            // Stale response: drop it and re-request at the new pc.
                            r_flush <= 1'b0;
                            r_state <= S_FETCH;
                        end
                    end else begin
                        // Memory still owns the old address; remember to discard its answer.
                        if (branch_taken) begin
                            r_flush <= 1'b1;
                        end
                        r_state <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    // A branch squashes the held instruction even if decode takes it.
                    if (branch_taken || inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req   = w_req;
    assign imem_addr  = w_addr;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a transaction-level model

module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_pc;
    logic [31:0] pcNext;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    always #5 clk = ~clk;

    instr_fetch #(.WIDTH(32), .RESET_PC(32'h0), .STEP(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (m_pc),
        .pcNext        (pcNext),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
    );

    // Model: an outstanding request (fresh = address follows pc, else latched),
    // a stale marker for it, and a single held instruction slot.
    bit          q_out, q_fresh, q_stale, h_have;
    logic [31:0] q_addr, h_inst, h_pc;
    logic [31:0] s_next, s_addr;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q_out = 0; q_fresh = 0; q_stale = 0; h_have = 0;
        q_addr = '0; h_inst = '0; h_pc = '0;
    endtask

    task automatic step(input bit a, input logic [31:0] d, input bit b,
                        input logic [31:0] t, input bit r);
        logic [31:0] e_addr, e_next;
        imem_ack = a; imem_rdata = d; branch_taken = b; branch_target = t; inst_ready = r;
        e_addr = q_out ? (q_fresh ? m_pc : q_addr) : 32'h0;
        if (b)                          e_next = t;
        else if (q_out && a && !q_stale) e_next = m_pc + 32'd4;
        else                            e_next = m_pc;
        #2;
        s_next = pcNext;
        s_addr = imem_addr;
        chk("imem_req", {31'b0, imem_req}, {31'b0, q_out});
        chk("imem_addr", imem_addr, e_addr);
        chk("pcNext", pcNext, e_next);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, h_have});
        if (h_have) begin
            chk("inst", inst, h_inst);
            chk("inst_pc", inst_pc, h_pc);
        end
        @(posedge clk);
        #1;
        if (q_out) begin
            if (a) begin
                if (!q_stale && !b) begin
                    h_have = 1; h_inst = d; h_pc = e_addr; q_out = 0;
                end else begin
                    q_stale = 0; q_fresh = 1;
                end
            end else begin
                q_addr = e_addr; q_fresh = 0;
                if (b) q_stale = 1;
            end
        end else if (h_have) begin
            if (b || r) begin
                h_have = 0; q_out = 1; q_fresh = 1;
            end
        end else begin
            q_out = 1; q_fresh = 1;
        end
        m_pc = e_next;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_pcNext", pcNext, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        reset = 1'b1;
        model_clear();
        m_pc = 32'h0;
    endtask

    initial begin
        reset = 1'b0; m_pc = 32'h50;
        imem_ack = 0; imem_rdata = '0; branch_taken = 0; branch_target = '0; inst_ready = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("por_req", {31'b0, imem_req}, 32'h0);
        chk("por_addr", imem_addr, 32'h0);
        chk("por_valid", {31'b0, inst_valid}, 32'h0);
        chk("por_inst", inst, 32'h0);
        chk("por_inst_pc", inst_pc, 32'h0);
        chk("por_pcNext", pcNext, 32'h0);
        m_pc = 32'h0;
        reset = 1'b1;

        // first fetch with immediate ack
        step(0, 0, 0, 0, 0);
        step(1, 32'hA, 0, 0, 0);
        chk("t1_pcNext", s_next, 32'h4);
        chk("t1_valid", {31'b0, inst_valid}, 32'h1);
        chk("t1_inst", inst, 32'hA);
        chk("t1_inst_pc", inst_pc, 32'h0);

        // decode stall in HOLD
        repeat (5) step(0, 32'hDEAD, 0, 0, 0);

        // delayed ack at pc=8
        m_pc = 32'h8;
        step(0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0);
        step(1, 32'h1234_5678, 0, 0, 0);
        chk("t3_addr", s_addr, 32'h8);
        chk("t3_pcNext", s_next, 32'hC);

        // branch while waiting
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h100, 0);
        chk("t4_pcNext", s_next, 32'h100);
        chk("t4_addr_old", s_addr, 32'hC);
        step(0, 0, 0, 0, 0);
        step(1, 32'hBAD, 0, 0, 0);
        chk("t4_no_valid", {31'b0, inst_valid}, 32'h0);
        step(0, 0, 0, 0, 0);
        chk("t4_new_addr", s_addr, 32'h100);
        step(1, 32'h77, 0, 0, 0);

        // branch in HOLD with decode ready
        step(0, 0, 1, 32'h40, 1);
        chk("t5_squash", {31'b0, inst_valid}, 32'h0);
        step(1, 32'h88, 0, 0, 0);
        chk("t5_addr", s_addr, 32'h40);

        // pc wrap
        step(0, 0, 0, 0, 1);
        m_pc = 32'hFFFF_FFFC;
        step(1, 32'h99, 0, 0, 0);
        chk("t6_wrap", s_next, 32'h0);

        // reset in the middle of WAIT
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(2) == 0), $urandom, ($urandom_range(7) == 0),
                     ($urandom & 32'hFFFF_FFFC), $urandom_range(1) == 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
